// File: rtl/cache_page_sequencer_if.sv
// QSPI command/status and SRAM primary-port bundle for the page sequencer.
// master = sequencer side, slave = QSPI device / SRAM side.
interface cache_page_sequencer_if #(
    parameter int ADDRESS_SIZE      = 24,
    parameter int SRAM_ADDRESS_SIZE = 8
);
    logic                         qspi_initialised;
    logic                         qspi_busy;
    logic                         qspi_wordComplete;
    logic [ADDRESS_SIZE-1:0]      qspi_address;
    logic                         qspi_changeAddress;
    logic                         qspi_requestData;
    logic                         qspi_storeData;
    logic                         sram_enable;
    logic                         sram_writeEnable;
    logic [SRAM_ADDRESS_SIZE-1:0] sram_address;
    logic                         sram_busy;

    modport master (
        input  qspi_initialised, qspi_busy, qspi_wordComplete,
        input  sram_busy,
        output qspi_address, qspi_changeAddress,
        output qspi_requestData, qspi_storeData,
        output sram_enable, sram_writeEnable, sram_address
    );

    modport slave (
        output qspi_initialised, qspi_busy, qspi_wordComplete,
        output sram_busy,
        input  qspi_address, qspi_changeAddress,
        input  qspi_requestData, qspi_storeData,
        input  sram_enable, sram_writeEnable, sram_address
    );
endinterface

// File: rtl/cache_page_sequencer.sv
// Moves whole cache pages between QSPI RAM and the cache SRAM, one word
// at a time. Optional CACHE_SEQUENCER_STATS_EN adds load/flush counters.
module cache_page_sequencer #(
    parameter int ADDRESS_SIZE             = 24,
    parameter int PAGE_INDEX_ADDRESS_SIZE  = 3,
    parameter int PAGE_DATA_ADDRESS_SIZE   = 5,
    parameter int PAGE_NUMBER_ADDRESS_SIZE =
        ADDRESS_SIZE - PAGE_DATA_ADDRESS_SIZE - 2,
    localparam int PAGE_COUNT = 1 << PAGE_INDEX_ADDRESS_SIZE
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic enable,
    input  logic [PAGE_COUNT*PAGE_NUMBER_ADDRESS_SIZE-1:0] pageNumbers,
    input  logic [PAGE_COUNT-1:0]              pageRequestLoad,
    input  logic [PAGE_COUNT-1:0]              pageRequestFlush,
    output logic [PAGE_COUNT-1:0]              pagePending,
    output logic                               busy,
    output logic [PAGE_INDEX_ADDRESS_SIZE-1:0] activePage,
`ifdef CACHE_SEQUENCER_STATS_EN
    output logic [15:0]                        loadCount,
    output logic [15:0]                        flushCount,
`endif
    cache_page_sequencer_if.master             bus
);
    localparam int SA = PAGE_INDEX_ADDRESS_SIZE + PAGE_DATA_ADDRESS_SIZE;

    typedef logic [PAGE_INDEX_ADDRESS_SIZE-1:0] page_t;
    typedef logic [PAGE_DATA_ADDRESS_SIZE-1:0]  word_t;

    typedef enum logic [2:0] {
        IDLE, SETUP, LOAD_REQ, LOAD_WRITE,
        FLUSH_READ, FLUSH_STORE, DONE
    } state_t;

    state_t state_q, state_d;
    logic [PAGE_COUNT-1:0] load_pend_q, load_pend_d;
    logic [PAGE_COUNT-1:0] flush_pend_q, flush_pend_d;
    logic [PAGE_COUNT-1:0] load_clr, flush_clr;
    page_t rr_ptr_q, rr_ptr_d;
    page_t active_q, active_d;
    word_t word_q, word_d;
    logic flush_op_q, flush_op_d;
    logic busy_q, busy_d;
    logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
    logic chg_q, chg_d;
    logic req_q, req_d;
    logic store_q, store_d;
    logic sen_q, sen_d;
    logic swe_q, swe_d;
    logic [SA-1:0] saddr_q, saddr_d;

    logic [PAGE_COUNT-1:0] pending;
    logic run;
    page_t sel_page;
    logic sel_valid;
    word_t word_next;

    assign pending   = load_pend_q | flush_pend_q;
    assign run       = enable && bus.qspi_initialised;
    assign word_next = word_q + 1'b1;

    function automatic logic [ADDRESS_SIZE-1:0] page_base(input page_t p);
        return {pageNumbers[int'(p)*PAGE_NUMBER_ADDRESS_SIZE +:
                            PAGE_NUMBER_ADDRESS_SIZE],
                {PAGE_DATA_ADDRESS_SIZE{1'b0}}, 2'b00};
    endfunction

    // Round-robin pick: first pending page at or after the pointer
    always_comb begin
        sel_page  = rr_ptr_q;
        sel_valid = 1'b0;
        for (int k = 0; k < PAGE_COUNT; k++) begin
            if (!sel_valid && pending[rr_ptr_q + page_t'(k)]) begin
                sel_valid = 1'b1;
                sel_page  = rr_ptr_q + page_t'(k);
            end
        end
    end

    // Transfer FSM next state, registered strobes and pending bookkeeping
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        active_d  = active_q;
        word_d    = word_q;
        flush_op_d = flush_op_q;
        busy_d    = busy_q;
        addr_d    = addr_q;
        chg_d     = 1'b0;
        req_d     = req_q;
        store_d   = store_q;
        sen_d     = sen_q;
        swe_d     = swe_q;
        saddr_d   = saddr_q;
        load_clr  = '0;
        flush_clr = '0;

        unique case (state_q)
            IDLE: begin
                if (run && sel_valid) begin
                    active_d   = sel_page;
                    flush_op_d = flush_pend_q[sel_page];
                    word_d     = '0;
                    busy_d     = 1'b1;
                    addr_d     = page_base(sel_page);
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                addr_d = page_base(active_q);
                if (!bus.qspi_busy) begin
                    chg_d = 1'b1;
                    if (flush_op_q) begin
                        sen_d   = 1'b1;
                        swe_d   = 1'b0;
                        saddr_d = {active_q, word_q};
                        state_d = FLUSH_READ;
                    end else begin
                        state_d = LOAD_REQ;
                    end
                end
            end
            LOAD_REQ: begin
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (bus.qspi_wordComplete) begin
                    req_d   = 1'b0;
                    sen_d   = 1'b1;
                    swe_d   = 1'b1;
                    saddr_d = {active_q, word_q};
                    state_d = LOAD_WRITE;
                end
            end
            LOAD_WRITE: begin
                if (!bus.sram_busy) begin
                    sen_d  = 1'b0;
                    swe_d  = 1'b0;
                    word_d = word_next;
                    if (word_q == '1) begin
                        state_d = DONE;
                    end else begin
                        req_d   = 1'b1;
                        state_d = LOAD_REQ;
                    end
                end
            end
            FLUSH_READ: begin
                if (!bus.sram_busy) begin
                    sen_d   = 1'b0;
                    store_d = 1'b1;
                    state_d = FLUSH_STORE;
                end
            end
            FLUSH_STORE: begin
                if (store_q && bus.qspi_wordComplete) begin
                    store_d = 1'b0;
                    word_d  = word_next;
                    if (word_q == '1) begin
                        state_d = DONE;
                    end else begin
                        sen_d   = 1'b1;
                        swe_d   = 1'b0;
                        saddr_d = {active_q, word_next};
                        state_d = FLUSH_READ;
                    end
                end
            end
            DONE: begin
                busy_d   = 1'b0;
                rr_ptr_d = active_q + 1'b1;
                if (flush_op_q) flush_clr[active_q] = 1'b1;
                else            load_clr[active_q]  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Losing enable or the device drops the page; it stays pending
        if (state_q != IDLE && state_q != DONE && !run) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            word_d  = '0;
            chg_d   = 1'b0;
            req_d   = 1'b0;
            store_d = 1'b0;
            sen_d   = 1'b0;
            swe_d   = 1'b0;
        end

        load_pend_d  = (load_pend_q & ~load_clr) | pageRequestLoad;
        flush_pend_d = (flush_pend_q & ~flush_clr) | pageRequestFlush;
    end

    // State and output registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            load_pend_q  <= '0;
            flush_pend_q <= '0;
            rr_ptr_q     <= '0;
            active_q     <= '0;
            word_q       <= '0;
            flush_op_q   <= 1'b0;
            busy_q       <= 1'b0;
            addr_q       <= '0;
            chg_q        <= 1'b0;
            req_q        <= 1'b0;
            store_q      <= 1'b0;
            sen_q        <= 1'b0;
            swe_q        <= 1'b0;
            saddr_q      <= '0;
        end else begin
            state_q      <= state_d;
            load_pend_q  <= load_pend_d;
            flush_pend_q <= flush_pend_d;
            rr_ptr_q     <= rr_ptr_d;
            active_q     <= active_d;
            word_q       <= word_d;
            flush_op_q   <= flush_op_d;
            busy_q       <= busy_d;
            addr_q       <= addr_d;
            chg_q        <= chg_d;
            req_q        <= req_d;
            store_q      <= store_d;
            sen_q        <= sen_d;
            swe_q        <= swe_d;
            saddr_q      <= saddr_d;
        end
    end

`ifdef CACHE_SEQUENCER_STATS_EN
    logic [15:0] load_cnt_q, load_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    // Count finished page operations, saturating
    always_comb begin
        load_cnt_d  = load_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (state_q != DONE && state_d == DONE) begin
            if (flush_op_q) begin
                if (flush_cnt_q != 16'hFFFF)
                    flush_cnt_d = flush_cnt_q + 16'd1;
            end else begin
                if (load_cnt_q != 16'hFFFF)
                    load_cnt_d = load_cnt_q + 16'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            load_cnt_q  <= '0;
            flush_cnt_q <= '0;
        end else begin
            load_cnt_q  <= load_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign loadCount  = load_cnt_q;
    assign flushCount = flush_cnt_q;
`endif

    assign pagePending            = pending;
    assign busy                   = busy_q;
    assign activePage             = active_q;
    assign bus.qspi_address       = addr_q;
    assign bus.qspi_changeAddress = chg_q;
    assign bus.qspi_requestData   = req_q;
    assign bus.qspi_storeData     = store_q;
    assign bus.sram_enable        = sen_q;
    assign bus.sram_writeEnable   = swe_q;
    assign bus.sram_address       = saddr_q;
endmodule
